mips_mainfsm: RTL

Multicycle MIPS main controller. Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-ALU/shared-memory datapath. It supersedes the single-cycle opcode decoder. It adds BNE, ANDI and ORI (enabled by parameter), zero-extended immediates, and an illegal-opcode trap state. Sits in the controller beside aludec, which still owns funct decoding when aluop=FUNCT.

---
 rtl/mips_mainfsm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_mainfsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Control outputs are registered alongside the state so each one matches the state it belongs to.
module mips_mainfsm #(
    parameter bit EXT_EN  = 1'b1,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        ERROR  = 4'd15
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } ctrl_t;

    state_t cur_q, nxt_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Control word for a state; op only matters for IMMEX and the BRANCH qualifiers.
    function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = ALU_FUNCT;
            end
            ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca  = 1'b1;
                c.aluop    = ALU_SUB;
                c.pcsrc    = 2'b01;
                c.branch   = (o == OP_BEQ);
                c.branchne = (o == OP_BNE);
            end
            IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (o)
                    OP_ANDI: begin
                        c.aluop   = ALU_AND;
                        c.zeroext = 1'b1;
                    end
                    OP_ORI: begin
                        c.aluop   = ALU_OR;
                        c.zeroext = 1'b1;
                    end
                    default: c.aluop = ALU_ADD;
                endcase
            end
            IMMWB: c.regwrite = 1'b1;
            JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            ERROR: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection, then the control word that goes with that state.
    always_comb begin
        state_t illegal_nxt;
        nxt_d       = FETCH;
        illegal_nxt = TRAP_EN ? ERROR : FETCH;
        case (cur_q)
            FETCH:  nxt_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_d = MEMADR;
                    OP_RTYPE:     nxt_d = EXEC;
                    OP_BEQ:       nxt_d = BRANCH;
                    OP_BNE:       nxt_d = EXT_EN ? BRANCH : illegal_nxt;
                    OP_ADDI:      nxt_d = IMMEX;
                    OP_ANDI,
                    OP_ORI:       nxt_d = EXT_EN ? IMMEX : illegal_nxt;
                    OP_J:         nxt_d = JUMP;
                    default:      nxt_d = illegal_nxt;
                endcase
            end
            MEMADR: nxt_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt_d = MEMWB;
            EXEC:   nxt_d = ALUWB;
            IMMEX:  nxt_d = IMMWB;
            ERROR:  nxt_d = ERROR;
            default: nxt_d = FETCH;
        endcase
        ctrl_d = decode(nxt_d, op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= FETCH;
            ctrl_q <= decode(FETCH, op);
        end else begin
            cur_q  <= nxt_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign state    = cur_q;
    assign pcwrite  = ctrl_q.pcwrite;
    assign branch   = ctrl_q.branch;
    assign branchne = ctrl_q.branchne;
    assign iord     = ctrl_q.iord;
    assign memwrite = ctrl_q.memwrite;
    assign irwrite  = ctrl_q.irwrite;
    assign regdst   = ctrl_q.regdst;
    assign memtoreg = ctrl_q.memtoreg;
    assign regwrite = ctrl_q.regwrite;
    assign alusrca  = ctrl_q.alusrca;
    assign alusrcb  = ctrl_q.alusrcb;
    assign zeroext  = ctrl_q.zeroext;
    assign pcsrc    = ctrl_q.pcsrc;
    assign aluop    = ctrl_q.aluop;
    assign illegal  = ctrl_q.illegal;

endmodule
